viterbi_codec: RTL and testbench
================================

# viterbi_codec

Rate-1/2, constraint-length-3 convolutional encoder (`encoder`) and matching hard-decision Viterbi decoder (`decoder`), delivered together as one block. The encoder sits on the transmit side. The decoder sits after the (possibly corrupting) channel register. It recovers the original bit stream at a fixed latency, correcting isolated symbol errors.

## Interface
Parameters (shared by both modules, fixed in package):
- K, 3: constraint length; 4 trellis states.
- G0, 3'b111: generator for code bit 1 (`d_out[1]`).
- G1, 3'b101: generator for code bit 0 (`d_out[0]`).
- TB_DEPTH, 32: survivor path length in symbols.
- METRIC_W, 6: path-metric width.

Both modules use one clock; reset is asynchronous and active-low.

`encoder` ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- enable_i  in  1  input bit valid this cycle.
- d_in  in  1  information bit.
- valid_o  out  1  `d_out` holds a new code symbol.
- d_out  out  2  code symbol `{g0, g1}`.

`decoder` ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  `d_in` holds a valid received symbol.
- d_in  in  2  received hard symbol `{g0, g1}`.
- d_out  out  1  decoded bit.

## Operation
- **Encoder state:** 2-bit register `sr = {u[t-1], u[t-2]}`.
- **Encoder, on edge with `enable_i`=1:**
  - `d_out <= {d_in^sr[1]^sr[0], d_in^sr[0]}`.
  - `sr <= {d_in, sr[1]}`.
  - `valid_o <= 1`.
- **Encoder, `enable_i`=0:** `sr` and `d_out` hold; `valid_o <= 0`.
- **Decoder state numbering:** state s = `{u[t-1], u[t-2]}`. Input b moves state s to next state `{b, s[1]}`.
  - Expected symbol for that transition: `{b^s[1]^s[0], b^s[0]}`.
- **Branch metric:** Hamming distance between `d_in` and the expected symbol (0..2).
- **Add-compare-select, per next state s' = `{b,x}`:**
  - Predecessors are `{x,0}` and `{x,1}`.
  - New metric = min(pm[pred] + bm) over the two predecessors, computed with saturating add at 2^METRIC_W−1.
  - On a tie, select the predecessor with LSB 0.
- **Normalization:** after ACS, subtract the minimum of the four new metrics from all four, in the same cycle.
- **Survivors (register exchange):** `path[s'] <= {path[pred][TB_DEPTH-2:0], b}`.
- **Output:**
  - `best` = state with minimum new metric; lowest index wins ties.
  - `d_out <= new path[best][TB_DEPTH-1]`.
- **`enable`=0:** metrics, paths and `d_out` all hold.

## Timing
- **Reset values:**
  - `encoder`: `sr`=0, `d_out`=2'b00, `valid_o`=0.
  - `decoder`: pm[0]=0, pm[1..3]=8, all paths 0, `d_out`=0.
- **Encoder latency:** one cycle from `enable_i`/`d_in` to `valid_o`/`d_out`. `valid_o` is `enable_i` delayed one cycle.
- **Decoder latency:**
  - After the edge that consumes the n-th enabled symbol (n from 0), `d_out` = u[n−31].
  - For n<31, `d_out` is 0 (reset-filled survivors).
  - Latency counts enabled symbols; idle cycles do not advance it.
- **Direct connection:** encoder `valid_o`→decoder `enable` and `d_out`→`d_in`, either wired directly or through one matched register stage, decodes correctly.
- **Mid-stream reset:** reset asserted mid-stream forces all reset values immediately, regardless of the clock.
- **Metric saturation:** a saturated metric never wraps.

## Structure
- **Package `viterbi_pkg`:** K, G0, G1, TB_DEPTH, METRIC_W, the 2-bit state typedef, and the expected-symbol function.
- **Sub-module `viterbi_acs`:** one instance per state. Takes two predecessor metrics, two branch metrics and the input bit; returns the new metric and select bit.
- **Modules:** `encoder` and `decoder` are separate modules in the block.

## Test plan
- **Reset:** assert reset mid-operation → encoder `d_out`=00, `valid_o`=0; decoder `d_out`=0 immediately.
- **Encoder impulse:** `enable_i`=1, `d_in` = 1,0,0,0 → `d_out` = 11,10,11,00 on consecutive cycles, `valid_o`=1 from the cycle after the first enable.
- **Clean loopback:** 256 random bits, encoder→decoder → `d_out` equals input delayed exactly 31 symbols, 0 bit errors.
- **Single-symbol corruption:** flip both bits of one symbol (index 100) → decoded stream is still error-free.
- **Gapped enable:** deassert `enable_i` on random cycles → the encoder and decoder hold state, and the decoded stream is still an exact 31-symbol-delayed copy.
- **All-zero input:** 200 symbols of 00 → pm[0] stays 0 and `d_out` stays 0 throughout.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants, types and helpers for the rate-1/2, K=3 convolutional
// encoder and its hard-decision Viterbi decoder.
package viterbi_pkg;

  localparam int          K          = 3;
  localparam logic [2:0]  G0         = 3'b111;
  localparam logic [2:0]  G1         = 3'b101;
  localparam int          TB_DEPTH   = 32;
  localparam int          METRIC_W   = 6;
  localparam int          NUM_STATES = 1 << (K - 1);

  typedef logic [K-2:0]        state_t;
  typedef logic [METRIC_W-1:0] metric_t;
  typedef logic [TB_DEPTH-1:0] path_t;

  localparam metric_t METRIC_MAX  = '1;
  localparam metric_t METRIC_INIT = metric_t'(8);

  // Code symbol {g0, g1} emitted when bit b enters a coder in state s = {u[t-1], u[t-2]}.
  function automatic logic [1:0] expected_symbol(input logic b, input state_t s);
    logic [2:0] taps;
    taps = {b, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  function automatic metric_t sat_add(input metric_t a, input logic [1:0] bm);
    logic [METRIC_W:0] sum;
    sum = {1'b0, a} + {{(METRIC_W - 1){1'b0}}, bm};
    return sum[METRIC_W] ? METRIC_MAX : sum[METRIC_W-1:0];
  endfunction

endpackage

// File: rtl/decoder.sv
// Hard-decision Viterbi decoder, register-exchange survivors, decision taken
// from the oldest bit of the best state's survivor.
module decoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  metric_t pm_reg   [NUM_STATES];
  path_t   path_reg [NUM_STATES];
  metric_t pm_acs   [NUM_STATES];
  path_t   path_acs [NUM_STATES];
  metric_t pm_next  [NUM_STATES];
  metric_t pm_min;
  state_t  best;

  generate
    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_acs
      // Next state {b, x} is reached from {x, 0} and {x, 1}.
      localparam logic   B  = 1'((gi >> 1) & 1);
      localparam logic   X  = 1'(gi & 1);
      localparam state_t P0 = {X, 1'b0};
      localparam state_t P1 = {X, 1'b1};

      logic [1:0] bm0;
      logic [1:0] bm1;
      logic [1:0] diff0;
      logic [1:0] diff1;

      always_comb begin
        diff0 = d_in ^ expected_symbol(B, P0);
        diff1 = d_in ^ expected_symbol(B, P1);
        bm0   = {1'b0, diff0[1]} + {1'b0, diff0[0]};
        bm1   = {1'b0, diff1[1]} + {1'b0, diff1[0]};
      end

      viterbi_acs u_acs (
        .pm0      (pm_reg[P0]),
        .pm1      (pm_reg[P1]),
        .bm0      (bm0),
        .bm1      (bm1),
        .b        (B),
        .path0    (path_reg[P0]),
        .path1    (path_reg[P1]),
        .pm_new   (pm_acs[gi]),
        .path_new (path_acs[gi])
      );

      assign pm_next[gi] = pm_acs[gi] - pm_min;
    end
  endgenerate

  // Strict comparison keeps the lowest index on ties.
  always_comb begin
    pm_min = pm_acs[0];
    best   = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (pm_acs[i] < pm_min) begin
        pm_min = pm_acs[i];
        best   = state_t'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_reg[i]   <= (i == 0) ? '0 : METRIC_INIT;
        path_reg[i] <= '0;
      end
      d_out <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_reg[i]   <= pm_next[i];
        path_reg[i] <= path_acs[i];
      end
      d_out <= path_acs[best][TB_DEPTH-1];
    end
  end

endmodule

// File: rtl/encoder.sv
// Rate-1/2, K=3 convolutional encoder with a one-cycle registered output.
module encoder
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  state_t sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      d_out   <= 2'b00;
      valid_o <= 1'b0;
    end else begin
      valid_o <= enable_i;
      if (enable_i) begin
        d_out <= expected_symbol(d_in, sr);
        sr    <= {d_in, sr[1]};
      end
    end
  end

endmodule

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; also forms that state's survivor.
module viterbi_acs
  import viterbi_pkg::*;
(
  input  metric_t    pm0,
  input  metric_t    pm1,
  input  logic [1:0] bm0,
  input  logic [1:0] bm1,
  input  logic       b,
  input  path_t      path0,
  input  path_t      path1,
  output metric_t    pm_new,
  output path_t      path_new
);

  metric_t cand0;
  metric_t cand1;
  logic    sel;

  // A tie keeps the predecessor whose LSB is 0.
  always_comb begin
    cand0    = sat_add(pm0, bm0);
    cand1    = sat_add(pm1, bm1);
    sel      = (cand1 < cand0);
    pm_new   = sel ? cand1 : cand0;
    path_new = sel ? {path1[TB_DEPTH-2:0], b} : {path0[TB_DEPTH-2:0], b};
  end

endmodule

// File: rtl/viterbi_codec.sv
// Encoder and decoder side by side; the channel between them is external.
module viterbi_codec
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable,
  input  logic       enc_d_in,
  output logic       enc_valid,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out
);

  encoder u_enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_enable),
    .d_in     (enc_d_in),
    .valid_o  (enc_valid),
    .d_out    (enc_d_out)
  );

  decoder u_dec (
    .clk    (clk),
    .rst    (rst),
    .enable (dec_enable),
    .d_in   (dec_d_in),
    .d_out  (dec_d_out)
  );

endmodule

// File: tb/tb_viterbi_codec.sv
// Self-checking bench: encoder -> one-stage channel (optional corruption) -> decoder.
module tb_viterbi_codec;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable = 1'b0;
  logic       enc_d_in = 1'b0;
  logic       enc_valid;
  logic [1:0] enc_d_out;
  logic       dec_enable = 1'b0;
  logic [1:0] dec_d_in = 2'b00;
  logic       dec_d_out;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  viterbi_codec dut (
    .clk        (clk),
    .rst        (rst),
    .enc_enable (enc_enable),
    .enc_d_in   (enc_d_in),
    .enc_valid  (enc_valid),
    .enc_d_out  (enc_d_out),
    .dec_enable (dec_enable),
    .dec_d_in   (dec_d_in),
    .dec_d_out  (dec_d_out)
  );

  task automatic do_reset();
    @(negedge clk);
    enc_enable = 1'b0;
    dec_enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // mode: 0 random, 1 all ones, 2 all zeros. Starts right after do_reset.
  task automatic run_loopback(input string name, input int nbits, input int mode,
                              input int corrupt_idx, input bit gaps);
    bit         u_hist[$];
    bit         exp_q[$];
    logic [1:0] model_sr = 2'b00;
    logic [1:0] exp_sym = 2'b00;
    logic [1:0] prev_enc = 2'b00;
    logic       prev_dec = 1'b0;
    bit         dec_seen, enc_seen, b, e;
    int         sent = 0, sym_idx = 0, got = 0, errs = 0, cyc = 0;
    int         budget = nbits * 4 + 100;
    while (got < nbits && cyc < budget) begin
      @(negedge clk);
      cyc++;
      // channel register stage modelled at the falling edge
      dec_enable = enc_valid;
      dec_d_in   = enc_d_out ^ ((enc_valid && sym_idx == corrupt_idx) ? 2'b11 : 2'b00);
      if (enc_valid) sym_idx++;
      dec_seen = dec_enable;
      prev_enc = enc_d_out;
      prev_dec = dec_d_out;
      enc_seen = 1'b0;
      if (sent < nbits && (!gaps || $urandom_range(3) != 0)) begin
        b = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(1));
        enc_enable = 1'b1;
        enc_d_in   = b;
        enc_seen   = 1'b1;
        exp_sym    = {b ^ model_sr[1] ^ model_sr[0], b ^ model_sr[0]};
        model_sr   = {b, model_sr[1]};
        exp_q.push_back((sent >= 31) ? u_hist[sent - 31] : 1'b0);
        u_hist.push_back(b);
        sent++;
      end else begin
        enc_enable = 1'b0;
      end
      @(posedge clk);
      #1;
      if (enc_seen) begin
        checks++;
        if (enc_valid === 1'b1 && enc_d_out === exp_sym) passed++;
        else $display("FAIL %s enc_sym[%0d]: got valid=%b sym=%b, want valid=1 sym=%b",
                      name, sent - 1, enc_valid, enc_d_out, exp_sym);
      end else if (gaps && sent > 0) begin
        checks++;
        if (enc_valid === 1'b0 && enc_d_out === prev_enc) passed++;
        else $display("FAIL %s enc_hold: got valid=%b sym=%b, want valid=0 sym=%b",
                      name, enc_valid, enc_d_out, prev_enc);
      end
      if (dec_seen) begin
        e = exp_q.pop_front();
        if (dec_d_out !== e) begin
          errs++;
          $display("FAIL %s dec_bit[%0d]: got %b, want %b", name, got, dec_d_out, e);
        end
        got++;
      end else if (gaps) begin
        checks++;
        if (dec_d_out === prev_dec) passed++;
        else $display("FAIL %s dec_hold: got %b, want %b", name, dec_d_out, prev_dec);
      end
      if (mode == 2) begin
        checks++;
        if (dut.u_dec.pm_reg[0] === 6'd0 && dec_d_out === 1'b0) passed++;
        else $display("FAIL %s zero_pm0: got pm0=%0d d_out=%b, want pm0=0 d_out=0",
                      name, dut.u_dec.pm_reg[0], dec_d_out);
      end
    end
    enc_enable = 1'b0;
    checks++;
    if (got == nbits && errs == 0) passed++;
    else $display("FAIL %s stream: got %0d/%0d bits with %0d errors, want %0d bits, 0 errors",
                  name, got, nbits, errs, nbits);
    $display("%s: %0d symbols decoded, %0d bit errors", name, got, errs);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (enc_valid === 1'b0 && enc_d_out === 2'b00 && dec_d_out === 1'b0) passed++;
    else $display("FAIL reset_init: got valid=%b sym=%b dec=%b, want 0 00 0",
                  enc_valid, enc_d_out, dec_d_out);
    run_loopback("reset_preload", 40, 1, -1, 1'b0);
    checks++;
    if (dec_d_out === 1'b1 && enc_d_out === 2'b10) passed++;
    else $display("FAIL reset_pre: got dec=%b sym=%b, want dec=1 sym=10", dec_d_out, enc_d_out);
    // keep the stream running and assert reset between clock edges
    @(negedge clk);
    enc_enable = 1'b1;
    enc_d_in   = 1'b1;
    dec_enable = 1'b1;
    dec_d_in   = 2'b10;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (enc_valid === 1'b0 && enc_d_out === 2'b00 && dec_d_out === 1'b0) passed++;
    else $display("FAIL reset_async: got valid=%b sym=%b dec=%b, want 0 00 0",
                  enc_valid, enc_d_out, dec_d_out);
    checks++;
    if (dut.u_dec.pm_reg[0] === 6'd0 && dut.u_dec.pm_reg[3] === 6'd8) passed++;
    else $display("FAIL reset_pm: got pm0=%0d pm3=%0d, want 0 8",
                  dut.u_dec.pm_reg[0], dut.u_dec.pm_reg[3]);
    $display("reset: mid-stream asynchronous reset applied");
    @(negedge clk);
    enc_enable = 1'b0;
    dec_enable = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_encoder_impulse();
    logic [1:0] want [4];
    logic [3:0] bits;
    want[0] = 2'b11; want[1] = 2'b10; want[2] = 2'b11; want[3] = 2'b00;
    bits = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enc_enable = 1'b1;
      enc_d_in   = bits[i];
      @(posedge clk);
      #1;
      checks++;
      if (enc_valid === 1'b1 && enc_d_out === want[i]) passed++;
      else $display("FAIL impulse[%0d]: got valid=%b sym=%b, want valid=1 sym=%b",
                    i, enc_valid, enc_d_out, want[i]);
      $display("impulse[%0d]: d_in=%b sym=%b", i, bits[i], enc_d_out);
    end
    @(negedge clk);
    enc_enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (enc_valid === 1'b0 && enc_d_out === 2'b00) passed++;
    else $display("FAIL impulse_idle: got valid=%b sym=%b, want valid=0 sym=00",
                  enc_valid, enc_d_out);
  endtask

  task automatic test_clean_loopback();
    do_reset();
    run_loopback("clean", 256, 0, -1, 1'b0);
  endtask

  task automatic test_corruption();
    do_reset();
    run_loopback("corrupt100", 256, 0, 100, 1'b0);
  endtask

  task automatic test_gapped();
    do_reset();
    run_loopback("gapped", 256, 0, -1, 1'b1);
  endtask

  task automatic test_all_zero();
    do_reset();
    run_loopback("all_zero", 200, 2, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_encoder_impulse();
    test_clean_loopback();
    test_corruption();
    test_gapped();
    test_all_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
